// File: rtl/pako_loader_pkg.sv
// Shared definitions for the program loader: command opcodes,
// response codes, FSM state encoding and the address check helper.
package pako_loader_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_GO    = 8'h47;
  localparam logic [7:0] OP_HALT  = 8'h48;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    MEM_WR,
    MEM_RD,
    RD_WAIT,
    TX_DATA,
    TX_STAT
  } state_e;

  // True when the byte address is word aligned and inside the memory.
  function automatic logic addr_valid(input logic [31:0] addr,
                                      input logic [32:0] limit);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: decodes W/R/G/H commands arriving from the
// CDC byte channel, writes or reads instruction memory, controls the CPU
// run enable and returns read data plus an ACK/NAK status byte.
module prog_loader
  import pako_loader_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i,
  output logic        run_o
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  state_e      state_q;
  logic        run_q;
  logic        is_wr_q;
  logic        out_ready_q;
  logic        in_valid_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic [1:0]  cnt_q;
  logic [31:0] shift_q;
  logic [31:0] addr_hold_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [7:0]  in_data_q;

  logic [31:0] shift_d;
  logic        consume;
  logic        tx_done;

  // Incoming bytes enter at the top so the first (least significant) byte
  // ends up in bits [7:0] after four shifts.
  always_comb begin
    shift_d = {out_data_i, shift_q[31:8]};
    consume = out_valid_i && out_ready_q;
    tx_done = in_valid_q && in_ready_i;
  end

  // Command FSM with all handshake and memory outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      is_wr_q     <= 1'b0;
      out_ready_q <= 1'b0;
      in_valid_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cnt_q       <= 2'd0;
      shift_q     <= 32'd0;
      addr_hold_q <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      in_data_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          out_ready_q <= 1'b1;
          if (consume) begin
            cnt_q <= 2'd0;
            if (out_data_i == OP_WRITE || out_data_i == OP_READ) begin
              is_wr_q <= (out_data_i == OP_WRITE);
              state_q <= ADDR;
            end else begin
              if (out_data_i == OP_GO) run_q <= 1'b1;
              if (out_data_i == OP_HALT) run_q <= 1'b0;
              in_data_q   <= (out_data_i == OP_GO || out_data_i == OP_HALT)
                             ? RSP_ACK : RSP_NAK;
              in_valid_q  <= 1'b1;
              out_ready_q <= 1'b0;
              state_q     <= TX_STAT;
            end
          end
        end
        ADDR: begin
          if (consume) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (is_wr_q) begin
                addr_hold_q <= shift_d;
                state_q     <= DATA;
              end else if (addr_valid(shift_d, ADDR_LIMIT)) begin
                mem_addr_q  <= shift_d;
                mem_re_q    <= 1'b1;
                out_ready_q <= 1'b0;
                state_q     <= MEM_RD;
              end else begin
                in_data_q   <= RSP_NAK;
                in_valid_q  <= 1'b1;
                out_ready_q <= 1'b0;
                state_q     <= TX_STAT;
              end
            end
          end
        end
        DATA: begin
          if (consume) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              out_ready_q <= 1'b0;
              if (addr_valid(addr_hold_q, ADDR_LIMIT) && !run_q) begin
                mem_addr_q  <= addr_hold_q;
                mem_wdata_q <= shift_d;
                mem_we_q    <= 1'b1;
                state_q     <= MEM_WR;
              end else begin
                in_data_q  <= RSP_NAK;
                in_valid_q <= 1'b1;
                state_q    <= TX_STAT;
              end
            end
          end
        end
        MEM_WR: begin
          mem_we_q   <= 1'b0;
          in_data_q  <= RSP_ACK;
          in_valid_q <= 1'b1;
          state_q    <= TX_STAT;
        end
        MEM_RD: begin
          mem_re_q <= 1'b0;
          state_q  <= RD_WAIT;
        end
        RD_WAIT: begin
          shift_q    <= mem_rdata_i;
          in_data_q  <= mem_rdata_i[7:0];
          in_valid_q <= 1'b1;
          cnt_q      <= 2'd0;
          state_q    <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_done) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              in_data_q <= RSP_ACK;
              state_q   <= TX_STAT;
            end else begin
              shift_q   <= {8'd0, shift_q[31:8]};
              in_data_q <= shift_q[15:8];
            end
          end
        end
        TX_STAT: begin
          if (tx_done) begin
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_ready_o = out_ready_q;
  assign in_data_o   = in_data_q;
  assign in_valid_o  = in_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_re_o    = mem_re_q;
  assign run_o       = run_q;

endmodule
